// File: rtl/regbus_arbiter.sv
// regbus_arbiter: two-master, one-slave register-bus arbiter.
// Master 0 (FSMC) and master 1 (SPI) share one register bank, with round-robin priority.
// A level request becomes a single-cycle wen/ren strobe to the slave.
// Read data returns to the granted master together with a one-cycle ack pulse.
module regbus_arbiter #(
    parameter int P_WIDTH_ADDR = 16,
    parameter int P_WIDTH_DATA = 16,
    parameter int P_RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req,
    input  logic                    m0_wr,
    input  logic [P_WIDTH_ADDR-1:0] m0_addr,
    input  logic [P_WIDTH_DATA-1:0] m0_wdata,
    output logic                    m0_ack,
    output logic [P_WIDTH_DATA-1:0] m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_wr,
    input  logic [P_WIDTH_ADDR-1:0] m1_addr,
    input  logic [P_WIDTH_DATA-1:0] m1_wdata,
    output logic                    m1_ack,
    output logic [P_WIDTH_DATA-1:0] m1_rdata,
    output logic [P_WIDTH_ADDR-1:0] s_addr,
    output logic [P_WIDTH_DATA-1:0] s_wdata,
    output logic                    s_wen,
    output logic                    s_ren,
    input  logic [P_WIDTH_DATA-1:0] s_rdata,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    // The read latency is at most 4, so a 3-bit counter always reaches it.
    localparam logic [2:0] RD_LAT = 3'(P_RD_LAT);

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant;
    logic [2:0]              lat_cnt;
    logic                    cmd_id;
    logic                    cmd_wr;
    logic [P_WIDTH_ADDR-1:0] cmd_addr;
    logic [P_WIDTH_DATA-1:0] cmd_wdata;
    logic                    grant_valid;
    logic                    grant_id;
    logic                    rd_capture;

    // Round-robin choice: a lone requester wins outright, and a tie goes to the master not served last.
    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_id    = (m0_req && m1_req) ? ~last_grant : m1_req;
    end

    // Next-state logic and bus/ack outputs. Strobes fire only in ISSUE, and acks fire only in ACK.
    always_comb begin
        state_next = state;
        s_wen      = 1'b0;
        s_ren      = 1'b0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        busy       = (state != IDLE);
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                s_wen      = cmd_wr;
                s_ren      = ~cmd_wr;
                state_next = cmd_wr ? ACK : WAIT;
            end
            WAIT: begin
                if (lat_cnt == RD_LAT) begin
                    rd_capture = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                m0_ack     = ~cmd_id;
                m1_ack     = cmd_id;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning command in IDLE. Later changes on the master's inputs are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_id;
            cmd_id     <= grant_id;
            cmd_wr     <= grant_id ? m1_wr : m0_wr;
            cmd_addr   <= grant_id ? m1_addr : m0_addr;
            cmd_wdata  <= grant_id ? m1_wdata : m0_wdata;
        end
    end

    // Read latency counter. It holds 1 in the first WAIT cycle and counts up until it reaches the slave latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt <= 3'd0;
        end else if (state == ISSUE) begin
            lat_cnt <= 3'd1;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
        end
    end

    // Capture slave read data for the granted master only. The other master's rdata is left untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (rd_capture) begin
            if (cmd_id) begin
                m1_rdata <= s_rdata;
            end else begin
                m0_rdata <= s_rdata;
            end
        end
    end

    assign s_addr  = cmd_addr;
    assign s_wdata = cmd_wdata;

endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: directed bench for regbus_arbiter.
// Two instances are built, one with read latency 1 and one with read latency 3.
// A transaction-level model predicts every output on every cycle.
module tb_regbus_arbiter;

    logic        clk;
    logic        rst_n    [2];
    logic        m0_req   [2];
    logic        m0_wr    [2];
    logic [15:0] m0_addr  [2];
    logic [15:0] m0_wdata [2];
    logic        m0_ack   [2];
    logic [15:0] m0_rdata [2];
    logic        m1_req   [2];
    logic        m1_wr    [2];
    logic [15:0] m1_addr  [2];
    logic [15:0] m1_wdata [2];
    logic        m1_ack   [2];
    logic [15:0] m1_rdata [2];
    logic [15:0] s_addr   [2];
    logic [15:0] s_wdata  [2];
    logic        s_wen    [2];
    logic        s_ren    [2];
    logic [15:0] s_rdata  [2];
    logic        busy     [2];

    int lat_of [2] = '{1, 3};
    int checks = 0;
    int errors = 0;

    regbus_arbiter #(.P_WIDTH_ADDR(16), .P_WIDTH_DATA(16), .P_RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .m0_req(m0_req[0]), .m0_wr(m0_wr[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
        .m0_ack(m0_ack[0]), .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req[0]), .m1_wr(m1_wr[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
        .m1_ack(m1_ack[0]), .m1_rdata(m1_rdata[0]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wen(s_wen[0]), .s_ren(s_ren[0]),
        .s_rdata(s_rdata[0]), .busy(busy[0])
    );

    regbus_arbiter #(.P_WIDTH_ADDR(16), .P_WIDTH_DATA(16), .P_RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .m0_req(m0_req[1]), .m0_wr(m0_wr[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
        .m0_ack(m0_ack[1]), .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req[1]), .m1_wr(m1_wr[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
        .m1_ack(m1_ack[1]), .m1_rdata(m1_rdata[1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wen(s_wen[1]), .s_ren(s_ren[1]),
        .s_rdata(s_rdata[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction model state. A nonzero phase means a transaction is in flight:
    // phase 1 is the strobe cycle, and phase len is the ack cycle.
    int          ph      [2];
    int          len     [2];
    logic        started [2] = '{1'b0, 1'b0};
    logic        mid     [2];
    logic        mwr     [2];
    logic        mlast   [2];
    logic [15:0] maddr   [2];
    logic [15:0] mwdata  [2];
    logic [15:0] mrd0    [2];
    logic [15:0] mrd1    [2];

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return ~last;
        return r1;
    endfunction

    // Model: advance each instance by one cycle, following the arbitration and timing rules.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                started[k] <= 1'b1;
                ph[k]      <= 0;
                len[k]     <= 0;
                mid[k]     <= 1'b0;
                mwr[k]     <= 1'b0;
                mlast[k]   <= 1'b1;
                maddr[k]   <= 16'h0;
                mwdata[k]  <= 16'h0;
                mrd0[k]    <= 16'h0;
                mrd1[k]    <= 16'h0;
            end else if (ph[k] == 0) begin
                if (m0_req[k] || m1_req[k]) begin
                    mid[k]    <= pick(m0_req[k], m1_req[k], mlast[k]);
                    mlast[k]  <= pick(m0_req[k], m1_req[k], mlast[k]);
                    mwr[k]    <= pick(m0_req[k], m1_req[k], mlast[k]) ? m1_wr[k] : m0_wr[k];
                    maddr[k]  <= pick(m0_req[k], m1_req[k], mlast[k]) ? m1_addr[k] : m0_addr[k];
                    mwdata[k] <= pick(m0_req[k], m1_req[k], mlast[k]) ? m1_wdata[k] : m0_wdata[k];
                    len[k]    <= (pick(m0_req[k], m1_req[k], mlast[k]) ? m1_wr[k] : m0_wr[k])
                                 ? 2 : 2 + lat_of[k];
                    ph[k]     <= 1;
                end
            end else begin
                if (!mwr[k] && ph[k] == 1 + lat_of[k]) begin
                    if (mid[k]) mrd1[k] <= s_rdata[k];
                    else        mrd0[k] <= s_rdata[k];
                end
                ph[k] <= (ph[k] == len[k]) ? 0 : ph[k] + 1;
            end
        end
    end

    // Compare every DUT output with the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (started[k]) begin
                check_bit($sformatf("dut%0d busy", k), busy[k], ph[k] != 0);
                check_bit($sformatf("dut%0d s_wen", k), s_wen[k], ph[k] == 1 && mwr[k]);
                check_bit($sformatf("dut%0d s_ren", k), s_ren[k], ph[k] == 1 && !mwr[k]);
                check_bit($sformatf("dut%0d m0_ack", k), m0_ack[k],
                          ph[k] != 0 && ph[k] == len[k] && !mid[k]);
                check_bit($sformatf("dut%0d m1_ack", k), m1_ack[k],
                          ph[k] != 0 && ph[k] == len[k] && mid[k]);
                check_word($sformatf("dut%0d s_addr", k), s_addr[k], maddr[k]);
                check_word($sformatf("dut%0d s_wdata", k), s_wdata[k], mwdata[k]);
                check_word($sformatf("dut%0d m0_rdata", k), m0_rdata[k], mrd0[k]);
                check_word($sformatf("dut%0d m1_rdata", k), m1_rdata[k], mrd1[k]);
            end
        end
    end

    task automatic set_master(input int k, input int m, input logic req, input logic wr,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if (m == 0) begin
            m0_req[k] = req; m0_wr[k] = wr; m0_addr[k] = addr; m0_wdata[k] = wdata;
        end else begin
            m1_req[k] = req; m1_wr[k] = wr; m1_addr[k] = addr; m1_wdata[k] = wdata;
        end
    endtask

    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[k] = 1'b1;
        @(negedge clk);
    endtask

    // One master transaction, starting from the current cycle r.
    // ack_n is the number of cycles after r at which the ack appears.
    // s_rdata carries rval only in cycle r+1+latency and carries junk in every other cycle.
    task automatic apply_stimulus(input int k, input int m, input logic wr,
                                  input logic [15:0] addr, input logic [15:0] wdata,
                                  input logic [15:0] rval, output int ack_n,
                                  output logic st_wen, output logic st_ren,
                                  output logic [15:0] st_addr, output logic [15:0] st_wdata);
        ack_n = 0; st_wen = 1'b0; st_ren = 1'b0; st_addr = 16'h0; st_wdata = 16'h0;
        set_master(k, m, 1'b1, wr, addr, wdata);
        s_rdata[k] = 16'hDEAD;
        for (int n = 1; n <= 20 && ack_n == 0; n++) begin
            @(negedge clk);
            s_rdata[k] = (n == 1 + lat_of[k]) ? rval : (16'hDEAD ^ 16'(n));
            if (n == 1) begin
                st_wen = s_wen[k]; st_ren = s_ren[k]; st_addr = s_addr[k]; st_wdata = s_wdata[k];
                set_master(k, m, 1'b1, wr, ~addr, ~wdata);
            end
            if ((m == 0 && m0_ack[k]) || (m == 1 && m1_ack[k])) ack_n = n;
        end
        set_master(k, m, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Both masters hold write requests until n acks have been seen.
    // Bit i of order holds the id of the master that received the i-th ack.
    task automatic run_both(input int k, input int n, output logic [3:0] order, output int got);
        order = 4'b0; got = 0;
        set_master(k, 0, 1'b1, 1'b1, 16'h0100, 16'hAAAA);
        set_master(k, 1, 1'b1, 1'b1, 16'h0200, 16'h5555);
        for (int c = 0; c < 40 && got < n; c++) begin
            @(negedge clk);
            if (m0_ack[k]) begin order[got] = 1'b0; got++; end
            else if (m1_ack[k]) begin order[got] = 1'b1; got++; end
        end
        set_master(k, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_master(k, 1, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    int          ack_n;
    logic        st_wen, st_ren;
    logic [15:0] st_addr, st_wdata;
    logic [3:0]  order;
    int          got;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            set_master(k, 0, 1'b0, 1'b0, 16'h0, 16'h0);
            set_master(k, 1, 1'b0, 1'b0, 16'h0, 16'h0);
            s_rdata[k] = 16'h0;
        end
        repeat (2) @(negedge clk);
        check_bit("reset busy", busy[0], 1'b0);
        check_word("reset s_addr", s_addr[0], 16'h0000);
        check_word("reset m0_rdata", m0_rdata[0], 16'h0000);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        $display("[TB] single write m0");
        apply_stimulus(0, 0, 1'b1, 16'h0002, 16'h1234, 16'h0, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_bit("wr s_wen", st_wen, 1'b1);
        check_bit("wr s_ren", st_ren, 1'b0);
        check_word("wr s_addr", st_addr, 16'h0002);
        check_word("wr s_wdata", st_wdata, 16'h1234);
        check_output("wr ack latency", ack_n, 2);
        @(negedge clk);

        $display("[TB] single read m1 latency 1");
        apply_stimulus(0, 1, 1'b0, 16'h0005, 16'h0, 16'hBEEF, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_bit("rd s_ren", st_ren, 1'b1);
        check_word("rd s_addr", st_addr, 16'h0005);
        check_output("rd ack latency", ack_n, 3);
        check_word("rd m1_rdata", m1_rdata[0], 16'hBEEF);
        check_word("rd m0_rdata kept", m0_rdata[0], 16'h0000);
        @(negedge clk);

        $display("[TB] simultaneous requests after reset");
        do_reset(0);
        run_both(0, 4, order, got);
        check_output("rr ack count", got, 4);
        check_word("rr grant order", {12'h0, order}, 16'h000A);
        @(negedge clk);

        $display("[TB] back-to-back m0 writes");
        apply_stimulus(0, 0, 1'b1, 16'h0030, 16'h0001, 16'h0, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_output("b2b ack 1", ack_n, 2);
        apply_stimulus(0, 0, 1'b1, 16'h0031, 16'h0002, 16'h0, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_output("b2b ack 2 spacing", ack_n, 3);
        apply_stimulus(0, 0, 1'b1, 16'h0032, 16'h0003, 16'h0, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_output("b2b ack 3 spacing", ack_n, 3);
        run_both(0, 1, order, got);
        check_output("b2b tie count", got, 1);
        check_bit("b2b tie goes to m1", order[0], 1'b1);
        @(negedge clk);

        $display("[TB] read latency 3");
        apply_stimulus(1, 0, 1'b0, 16'h0010, 16'h0, 16'h00A5, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_bit("lat3 s_ren", st_ren, 1'b1);
        check_output("lat3 ack latency", ack_n, 5);
        check_word("lat3 m0_rdata", m0_rdata[1], 16'h00A5);
        @(negedge clk);

        $display("[TB] reset during read");
        set_master(0, 0, 1'b1, 1'b0, 16'h0020, 16'h0);
        @(negedge clk);
        check_bit("mid-rst issue s_ren", s_ren[0], 1'b1);
        @(negedge clk);
        rst_n[0] = 1'b0;
        set_master(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        s_rdata[0] = 16'h1111;
        @(negedge clk);
        check_bit("mid-rst busy", busy[0], 1'b0);
        check_bit("mid-rst m0_ack", m0_ack[0], 1'b0);
        check_word("mid-rst s_addr", s_addr[0], 16'h0000);
        check_word("mid-rst m1_rdata", m1_rdata[0], 16'h0000);
        rst_n[0] = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 1, 1'b1, 16'h0040, 16'hC0DE, 16'h0, ack_n, st_wen, st_ren, st_addr, st_wdata);
        check_output("post-rst ack latency", ack_n, 2);
        check_word("post-rst s_wdata", st_wdata, 16'hC0DE);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
